decapsulator: RTL and testbench
===============================

Name: decapsulator

Overview:
- Receive-side counterpart of the transmit encapsulator.
- Takes encapsulated frames on an AXI-Stream input and strips the outer header (MAC, MAC+VLAN, IPv4, UDP, NVGRE or VXLAN) selected per-TID.
- Re-aligns the remaining payload to byte lane 0 and emits it on an AXI-Stream output.
- Sits between the network port and the per-tenant NMU datapath.

Parameters:
AXIS_BUS_WIDTH, 64, data width in bits (multiple of 64); NB = AXIS_BUS_WIDTH/8
AXIS_ID_WIDTH, 4, tid width (effective minimum 1)
AXIS_DEST_WIDTH, 4, tdest width (effective minimum 1)
ALLOW_MAC_DECAP, 1, enable modes 2/3
ALLOW_IP4_DECAP, 1, enable mode 4
ALLOW_UDP_DECAP, 1, enable mode 5
ALLOW_NVGRE_DECAP, 1, enable mode 6
ALLOW_VXLAN_DECAP, 1, enable mode 7

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
axis_in_tdata  in  AXIS_BUS_WIDTH  encapsulated frame data
axis_in_tid  in  EFF_ID_WIDTH  tenant id
axis_in_tdest  in  EFF_DEST_WIDTH  destination
axis_in_tkeep  in  NB  byte enables; contiguous from lane 0, partial only on tlast
axis_in_tlast  in  1  end of frame
axis_in_tvalid  in  1  valid
axis_in_tready  out  1  ready
axis_out_tdata  out  AXIS_BUS_WIDTH  decapsulated data
axis_out_tid  out  EFF_ID_WIDTH  tid of frame
axis_out_tdest  out  EFF_DEST_WIDTH  tdest of frame
axis_out_tkeep  out  NB  byte enables, contiguous from lane 0
axis_out_tlast  out  1  end of frame
axis_out_tvalid  out  1  valid
axis_out_tready  in  1  ready
decap_sel_id  out  EFF_ID_WIDTH  equals axis_in_tid; config lookup index
decap_mode  in  3  header to strip for decap_sel_id

Behaviour:
- Strip length H by mode:
  - 0/1: 0 (pass-through)
  - 2: 14
  - 3: 18
  - 4: 34
  - 5: 42
  - 6: 42
  - 7: 50
- A mode whose ALLOW_* flag is 0 is treated as H=0.
- Derived values: S = H div NB (whole beats discarded); O = H mod NB (lane offset).
- decap_mode is sampled only on the first accepted beat of a frame. Mode, O, S, tid and tdest are latched for the rest of the frame.
- Registered output stage with one data register; axis_out_* change only when the register is empty or axis_out_tready=1.
- Reset (asynchronous, aresetn=0) clears:
  - axis_out_tvalid, tlast, tkeep, tdata, tid, tdest = 0
  - residue register empty
  - state = IDLE
- Reset mid-frame abandons the frame; the next accepted beat is treated as a first beat.
- FSM states: IDLE, SKIP, ALIGN, STREAM, FLUSH, DROP.
- IDLE:
  - On first beat accepted, latch the frame parameters.
  - H=0: forward the beat, go to STREAM.
  - S>0: discard the beat, set beat counter = 1, go to SKIP.
  - Otherwise (S=0): process the beat as in ALIGN.
- SKIP:
  - Discard beats until beat counter = S.
  - The next beat is processed in ALIGN.
- ALIGN (beat containing header end):
  - Lanes O..NB-1 are stored in the residue register (NB-O bytes); nothing is output.
  - If O=0, the beat is forwarded directly and the residue stays unused.
  - Go to STREAM, or handle as last beat (below).
- STREAM with O>0: each accepted beat outputs {current lanes 0..O-1, residue} with residue in the low lanes. Lanes O..NB-1 of the current beat become the new residue.
- Last input beat with k valid bytes:
  - (NB-O)+k <= NB: one output beat, tkeep = low (NB-O+k) ones, tlast=1, return to IDLE.
  - Otherwise: full beat without tlast, then FLUSH emits k-O bytes with tlast=1. axis_in_tready=0 during FLUSH.
- Short frame (tlast seen before or on the ALIGN beat with no payload byte past H): whole frame dropped, no output beat, return to IDLE.
- A tlast arriving during SKIP causes the same drop; DROP state is entered only if beats remain (not reachable with compliant tlast, but must be safe).
- axis_in_tready = output register free (empty or being drained), or beat being discarded (SKIP/drop), and not in FLUSH.
- Discarded beats are consumed at one per cycle regardless of axis_out_tready.
- Back-to-back frames: IDLE processing of the next first beat may occur in the cycle after the last output beat is registered; zero bubbles when O=0.
- Throughput: one beat/cycle except one extra FLUSH cycle when the tail overflows.
- Latency: one cycle from input accept to axis_out_tvalid.

Test Plan:
- Mode 0, 3-beat frame, last tkeep=0x0F -> identical 3 beats out, one cycle later, tkeep 0xFF,0xFF,0x0F, tlast on beat 3.
- Mode 5 (H=42, NB=8: S=5, O=2), 8-beat frame bytes 0..63 -> output bytes 42..63 in 3 beats, tkeep 0xFF,0xFF,0x3F, first out byte = 42.
- Mode 2 (H=14), frame of 24 bytes (last tkeep=0xFF) -> 10 bytes: beat 0xFF, then FLUSH beat tkeep=0x03 with tlast; tready low during FLUSH.
- Mode 7, 40-byte frame (shorter than 50) -> no output, tready high throughout, following mode-0 frame passes unchanged.
- Mode 4 with axis_out_tready toggled 1010… -> no byte lost/duplicated, tid/tdest constant per frame, decap_mode change mid-frame ignored.
- aresetn pulsed low during STREAM of a mode-6 frame -> tvalid 0 immediately, next frame decapsulated correctly from its first beat.

Source files
------------

// File: rtl/decapsulator.sv
// decapsulator: strips a per-tenant outer header from AXI-Stream frames and
// re-aligns the remaining payload to byte lane 0.
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   axis_in_*               encapsulated frames (tkeep contiguous, partial only on tlast)
//   axis_out_*              decapsulated frames, registered
//   decap_sel_id            tid presented to the external config table
//   decap_mode              header type returned by the config table (0..7)
module decapsulator #(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int AXIS_DEST_WIDTH   = 4,
    parameter int ALLOW_MAC_DECAP   = 1,
    parameter int ALLOW_IP4_DECAP   = 1,
    parameter int ALLOW_UDP_DECAP   = 1,
    parameter int ALLOW_NVGRE_DECAP = 1,
    parameter int ALLOW_VXLAN_DECAP = 1,
    localparam int NB             = AXIS_BUS_WIDTH / 8,
    localparam int EFF_ID_WIDTH   = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH,
    localparam int EFF_DEST_WIDTH = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [EFF_ID_WIDTH-1:0]   axis_in_tid,
    input  logic [EFF_DEST_WIDTH-1:0] axis_in_tdest,
    input  logic [NB-1:0]             axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [EFF_ID_WIDTH-1:0]   axis_out_tid,
    output logic [EFF_DEST_WIDTH-1:0] axis_out_tdest,
    output logic [NB-1:0]             axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,
    output logic [EFF_ID_WIDTH-1:0]   decap_sel_id,
    input  logic [2:0]                decap_mode
);

    localparam int OW = (NB > 1) ? $clog2(NB) : 1;
    localparam int KW = $clog2(NB + 1);

    typedef enum logic [2:0] {IDLE, SKIP, ALIGN, STREAM, FLUSH, DROP} state_t;

    function automatic int hdr_len(input logic [2:0] m);
        case (m)
            3'd2:    hdr_len = (ALLOW_MAC_DECAP != 0)   ? 14 : 0;
            3'd3:    hdr_len = (ALLOW_MAC_DECAP != 0)   ? 18 : 0;
            3'd4:    hdr_len = (ALLOW_IP4_DECAP != 0)   ? 34 : 0;
            3'd5:    hdr_len = (ALLOW_UDP_DECAP != 0)   ? 42 : 0;
            3'd6:    hdr_len = (ALLOW_NVGRE_DECAP != 0) ? 42 : 0;
            3'd7:    hdr_len = (ALLOW_VXLAN_DECAP != 0) ? 50 : 0;
            default: hdr_len = 0;
        endcase
    endfunction

    function automatic logic [NB-1:0] lo_ones(input int n);
        for (int i = 0; i < NB; i++) lo_ones[i] = (i < n);
    endfunction

    state_t                    state, nxt_state;
    logic [5:0]                cnt_q, cnt_d;
    logic [5:0]                s_q;
    logic [OW-1:0]             o_q;
    logic [EFF_ID_WIDTH-1:0]   tid_q;
    logic [EFF_DEST_WIDTH-1:0] dest_q;
    logic [AXIS_BUS_WIDTH-1:0] res_q, res_d;
    logic [KW-1:0]             flk_q, flk_d;
    logic                      ld_res, lat, ld_out, out_free, discard, acc;
    logic                      act_fwd, act_align, act_stream;
    logic [AXIS_BUS_WIDTH-1:0] o_data;
    logic [NB-1:0]             o_keep;
    logic                      o_last;
    logic [EFF_ID_WIDTH-1:0]   o_tid;
    logic [EFF_DEST_WIDTH-1:0] o_dest;
    int                        h_now, s_now, o_now, s_cur, o_cur, k_in;

    assign decap_sel_id = axis_in_tid;

    always_comb begin
        h_now = hdr_len(decap_mode);
        s_now = h_now / NB;
        o_now = h_now % NB;
        // decap_mode is only trusted on a frame's first beat
        s_cur = (state == IDLE) ? s_now : int'(s_q);
        o_cur = (state == IDLE) ? o_now : int'(o_q);
        k_in  = 0;
        for (int i = 0; i < NB; i++) if (axis_in_tkeep[i]) k_in += 1;

        out_free = !axis_out_tvalid || axis_out_tready;
        // discarded beats never touch the output register, so backpressure does not stall them
        discard  = (state == SKIP) || (state == DROP) || (state == IDLE && s_now != 0);
        axis_in_tready = (state != FLUSH) && (out_free || discard);
        acc = axis_in_tvalid && axis_in_tready;

        nxt_state  = state;
        cnt_d      = cnt_q;
        flk_d      = flk_q;
        lat        = 1'b0;
        ld_res     = 1'b0;
        res_d      = axis_in_tdata >> (8 * o_cur);
        ld_out     = 1'b0;
        o_data     = axis_in_tdata;
        o_keep     = axis_in_tkeep;
        o_last     = 1'b0;
        o_tid      = (state == IDLE) ? axis_in_tid : tid_q;
        o_dest     = (state == IDLE) ? axis_in_tdest : dest_q;
        act_fwd    = 1'b0;
        act_align  = 1'b0;
        act_stream = 1'b0;

        case (state)
            IDLE: if (acc) begin
                lat = 1'b1;
                if (h_now == 0) act_fwd = 1'b1;
                else if (s_now != 0) begin
                    cnt_d = 6'd1;
                    if (axis_in_tlast) nxt_state = IDLE;
                    else               nxt_state = (s_now == 1) ? ALIGN : SKIP;
                end else act_align = 1'b1;
            end
            SKIP: if (acc) begin
                if (axis_in_tlast) nxt_state = IDLE;   // frame ended inside the header
                else begin
                    cnt_d = cnt_q + 6'd1;
                    if (int'(cnt_q) + 1 == s_cur) nxt_state = ALIGN;
                end
            end
            ALIGN:  if (acc) act_align = 1'b1;
            STREAM: if (acc) begin
                if (o_cur == 0) act_fwd = 1'b1;
                else            act_stream = 1'b1;
            end
            FLUSH: if (out_free) begin
                ld_out    = 1'b1;
                o_data    = res_q;
                o_keep    = lo_ones(int'(flk_q));
                o_last    = 1'b1;
                nxt_state = IDLE;
            end
            DROP:    if (acc && axis_in_tlast) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        // beat holding the end of the header
        if (act_align) begin
            if (o_cur == 0) act_fwd = 1'b1;
            else if (k_in <= o_cur) begin
                // no payload past the header: drop; remaining beats (if any) go to DROP
                nxt_state = axis_in_tlast ? IDLE : DROP;
            end else if (axis_in_tlast) begin
                ld_out    = 1'b1;
                o_data    = axis_in_tdata >> (8 * o_cur);
                o_keep    = lo_ones(k_in - o_cur);
                o_last    = 1'b1;
                nxt_state = IDLE;
            end else begin
                ld_res    = 1'b1;
                nxt_state = STREAM;
            end
        end

        if (act_fwd) begin
            ld_out    = 1'b1;
            o_last    = axis_in_tlast;
            nxt_state = axis_in_tlast ? IDLE : STREAM;
        end

        // residue in low lanes, current beat's leading bytes on top
        if (act_stream) begin
            ld_out = 1'b1;
            o_data = res_q | (axis_in_tdata << (8 * (NB - o_cur)));
            o_keep = '1;
            if (!axis_in_tlast) ld_res = 1'b1;
            else if (k_in <= o_cur) begin
                o_keep    = lo_ones(NB - o_cur + k_in);
                o_last    = 1'b1;
                nxt_state = IDLE;
            end else begin
                ld_res    = 1'b1;
                flk_d     = KW'(k_in - o_cur);
                nxt_state = FLUSH;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            cnt_q           <= '0;
            s_q             <= '0;
            o_q             <= '0;
            tid_q           <= '0;
            dest_q          <= '0;
            res_q           <= '0;
            flk_q           <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
            axis_out_tkeep  <= '0;
            axis_out_tdata  <= '0;
            axis_out_tid    <= '0;
            axis_out_tdest  <= '0;
        end else begin
            state <= nxt_state;
            cnt_q <= cnt_d;
            flk_q <= flk_d;
            if (lat) begin
                s_q    <= 6'(s_now);
                o_q    <= OW'(o_now);
                tid_q  <= axis_in_tid;
                dest_q <= axis_in_tdest;
            end
            if (ld_res) res_q <= res_d;
            if (out_free) begin
                axis_out_tvalid <= ld_out;
                if (ld_out) begin
                    axis_out_tdata <= o_data;
                    axis_out_tkeep <= o_keep;
                    axis_out_tlast <= o_last;
                    axis_out_tid   <= o_tid;
                    axis_out_tdest <= o_dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_decapsulator.sv
// tb_decapsulator: directed bench for decapsulator (64-bit bus). Frames carry
// consecutive byte values, so each expected output beat is a byte range.
module tb_decapsulator;

    logic        aclk;
    logic        aresetn;
    logic [63:0] axis_in_tdata;
    logic [3:0]  axis_in_tid;
    logic [3:0]  axis_in_tdest;
    logic [7:0]  axis_in_tkeep;
    logic        axis_in_tlast;
    logic        axis_in_tvalid;
    logic        axis_in_tready;
    logic [63:0] axis_out_tdata;
    logic [3:0]  axis_out_tid;
    logic [3:0]  axis_out_tdest;
    logic [7:0]  axis_out_tkeep;
    logic        axis_out_tlast;
    logic        axis_out_tvalid;
    logic        axis_out_tready;
    logic [3:0]  decap_sel_id;
    logic [2:0]  decap_mode;

    decapsulator dut (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid),
        .axis_in_tdest(axis_in_tdest), .axis_in_tkeep(axis_in_tkeep),
        .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
        .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid),
        .axis_out_tdest(axis_out_tdest), .axis_out_tkeep(axis_out_tkeep),
        .axis_out_tlast(axis_out_tlast), .axis_out_tvalid(axis_out_tvalid),
        .axis_out_tready(axis_out_tready),
        .decap_sel_id(decap_sel_id), .decap_mode(decap_mode)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  tid;
        logic [3:0]  dest;
    } beat_t;

    beat_t got[$];
    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    bit    tog = 0;
    int    w;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // 1010... backpressure when enabled
    initial forever begin
        @(posedge aclk);
        #1;
        if (tog) axis_out_tready = ~axis_out_tready;
    end

    always @(negedge aclk)
        if (aresetn && axis_out_tvalid && axis_out_tready)
            got.push_back('{axis_out_tdata, axis_out_tkeep, axis_out_tlast,
                            axis_out_tid, axis_out_tdest});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [7:0] lo8(input int n);
        for (int i = 0; i < 8; i++) lo8[i] = (i < n);
    endfunction

    function automatic logic [63:0] mask64(input logic [7:0] k);
        mask64 = '0;
        for (int i = 0; i < 8; i++) if (k[i]) mask64[8*i +: 8] = 8'hFF;
    endfunction

    // expected beat: n consecutive byte values starting at first
    task automatic add_exp(input int first, input int n, input bit last,
                           input logic [3:0] tid, input logic [3:0] dest);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) b.data[8*i +: 8] = 8'(first + i);
        b.keep = lo8(n);
        b.last = last;
        b.tid  = tid;
        b.dest = dest;
        exp_q.push_back(b);
    endtask

    // sends nsend beats of an nbeats frame; last beat carries last_k bytes
    task automatic send_frame(input int base, input int nbeats, input int nsend, input int last_k,
                              input logic [2:0] mode0, input logic [2:0] mode_rest,
                              input logic [3:0] tid, input logic [3:0] dest,
                              input bit lat_chk, output int waits);
        bit rdy;
        int t;
        waits = 0;
        for (int b = 0; b < nsend; b++) begin
            for (int i = 0; i < 8; i++) axis_in_tdata[8*i +: 8] = 8'(base + 8*b + i);
            axis_in_tkeep  = (b == nbeats - 1) ? lo8(last_k) : 8'hFF;
            axis_in_tlast  = (b == nbeats - 1);
            axis_in_tid    = tid;
            axis_in_tdest  = dest;
            decap_mode     = (b == 0) ? mode0 : mode_rest;
            axis_in_tvalid = 1'b1;
            rdy = 1'b0;
            t = 0;
            while (!rdy) begin
                @(negedge aclk);
                rdy = axis_in_tready;
                @(posedge aclk);
                #1;
                if (!rdy) begin
                    waits++;
                    t++;
                    if (t > 100) begin
                        chk("send_tmo", 64'(t), 64'd0);
                        rdy = 1'b1;
                    end
                end
            end
            if (b == 0 && lat_chk) chk("latency", axis_out_tvalid, 1'b1);
        end
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
    endtask

    task automatic cmp_frame(input string tag);
        int c = 0;
        while (got.size() < exp_q.size() && c < 300) begin
            @(posedge aclk);
            c++;
        end
        repeat (4) @(posedge aclk);
        #1;
        chk({tag, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got[i].data & mask64(got[i].keep), exp_q[i].data);
            chk($sformatf("%s_keep%0d", tag, i), got[i].keep, exp_q[i].keep);
            chk($sformatf("%s_last%0d", tag, i), got[i].last, exp_q[i].last);
            chk($sformatf("%s_tid%0d",  tag, i), got[i].tid,  exp_q[i].tid);
            chk($sformatf("%s_dest%0d", tag, i), got[i].dest, exp_q[i].dest);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        axis_in_tdata = '0; axis_in_tid = 4'd2; axis_in_tdest = '0;
        axis_in_tkeep = '0; axis_in_tlast = 1'b0; axis_in_tvalid = 1'b0;
        axis_out_tready = 1'b1; decap_mode = 3'd0;
        #12;
        chk("rst_tvalid", axis_out_tvalid, 1'b0);
        chk("rst_tlast",  axis_out_tlast, 1'b0);
        chk("rst_tkeep",  axis_out_tkeep, 8'h00);
        chk("rst_tdata",  axis_out_tdata, 64'h0);
        chk("rst_tready", axis_in_tready, 1'b1);
        chk("sel_id",     decap_sel_id, 4'd2);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // mode 0 pass-through, partial tail
        add_exp(8'h80, 8, 0, 4'd1, 4'd2);
        add_exp(8'h88, 8, 0, 4'd1, 4'd2);
        add_exp(8'h90, 4, 1, 4'd1, 4'd2);
        send_frame(8'h80, 3, 3, 4, 3'd0, 3'd0, 4'd1, 4'd2, 1'b1, w);
        cmp_frame("m0");

        // mode 5: H=42 -> bytes 42..63
        add_exp(42, 8, 0, 4'd6, 4'd7);
        add_exp(50, 8, 0, 4'd6, 4'd7);
        add_exp(58, 6, 1, 4'd6, 4'd7);
        send_frame(0, 8, 8, 8, 3'd5, 3'd5, 4'd6, 4'd7, 1'b0, w);
        cmp_frame("m5");

        // mode 2: 24-byte frame -> 10 bytes, tail overflows into FLUSH
        add_exp(14, 8, 0, 4'd3, 4'd1);
        add_exp(22, 2, 1, 4'd3, 4'd1);
        send_frame(0, 3, 3, 8, 3'd2, 3'd2, 4'd3, 4'd1, 1'b0, w);
        chk("m2_flush_tready", axis_in_tready, 1'b0);
        @(posedge aclk); #1;
        chk("m2_idle_tready", axis_in_tready, 1'b1);
        cmp_frame("m2");

        // mode 7: 40-byte frame shorter than header -> dropped, then mode 0 frame
        send_frame(8'h40, 5, 5, 8, 3'd7, 3'd7, 4'd4, 4'd4, 1'b0, w);
        chk("m7_stalls", 64'(w), 64'd0);
        add_exp(8'hA0, 8, 0, 4'd8, 4'd9);
        add_exp(8'hA8, 8, 1, 4'd8, 4'd9);
        send_frame(8'hA0, 2, 2, 8, 3'd0, 3'd0, 4'd8, 4'd9, 1'b0, w);
        cmp_frame("m7_then_m0");

        // mode 4 with toggling backpressure, mode changed after first beat
        tog = 1'b1;
        add_exp(34, 8, 0, 4'd5, 4'd9);
        add_exp(42, 8, 0, 4'd5, 4'd9);
        add_exp(50, 8, 0, 4'd5, 4'd9);
        add_exp(58, 8, 0, 4'd5, 4'd9);
        add_exp(66, 8, 0, 4'd5, 4'd9);
        add_exp(74, 6, 1, 4'd5, 4'd9);
        send_frame(0, 10, 10, 8, 3'd4, 3'd0, 4'd5, 4'd9, 1'b0, w);
        cmp_frame("m4_bp");
        tog = 1'b0;
        @(posedge aclk); #2;
        axis_out_tready = 1'b1;
        @(posedge aclk); #1;

        // mode 6: reset during STREAM, then a clean frame
        send_frame(0, 8, 7, 8, 3'd6, 3'd6, 4'd3, 4'd4, 1'b0, w);
        aresetn = 1'b0;
        #1;
        chk("m6_rst_tvalid", axis_out_tvalid, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        got.delete();
        add_exp(42, 8, 0, 4'd3, 4'd4);
        add_exp(50, 8, 0, 4'd3, 4'd4);
        add_exp(58, 6, 1, 4'd3, 4'd4);
        send_frame(0, 8, 8, 8, 3'd6, 3'd6, 4'd3, 4'd4, 1'b0, w);
        cmp_frame("m6_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
